// File: rtl/chip8_blitter.sv
// rtl/chip8_blitter.sv - CHIP-8/SCHIP framebuffer blitter: sprite XOR-draw, clear and scroll
// Ports:
//   clk, res             clock, asynchronous active-high reset
//   hires                1: 128x64 active area, 0: 64x32 (top-left of buffer)
//   op/src/srcHeight     operation, sprite source address, sprite row count
//   destX/destY          sprite position; destY[3:0] is the SCROLL_DOWN distance
//   enable / done        start strobe (sampled when idle) / idle and not starting
//   collision            last sprite cleared at least one set pixel
//   ram_en/ram_addr/ram_out   main RAM read port, data one cycle after ram_en
//   fb_en/fb_wr/fb_addr/fb_in/fb_out  framebuffer port, read data one cycle after fb_en
module chip8_blitter #(
    parameter int SCROLL_X = 4
) (
    input  logic        clk,
    input  logic        res,
    input  logic        hires,
    input  logic [2:0]  op,
    input  logic [11:0] src,
    input  logic [3:0]  srcHeight,
    input  logic [6:0]  destX,
    input  logic [5:0]  destY,
    input  logic        enable,
    output logic        done,
    output logic        collision,
    output logic        ram_en,
    output logic [11:0] ram_addr,
    input  logic [7:0]  ram_out,
    output logic        fb_en,
    output logic        fb_wr,
    output logic [9:0]  fb_addr,
    output logic [7:0]  fb_in,
    input  logic [7:0]  fb_out
);

    localparam logic [2:0] OP_CLEAR        = 3'd0;
    localparam logic [2:0] OP_SPRITE       = 3'd1;
    localparam logic [2:0] OP_SPRITE16     = 3'd2;
    localparam logic [2:0] OP_SCROLL_DOWN  = 3'd3;
    localparam logic [2:0] OP_SCROLL_RIGHT = 3'd4;
    localparam logic [2:0] OP_SCROLL_LEFT  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_FETCH, S_FETCH2, S_CAPTURE,
        S_SP_RD, S_SP_WAIT, S_SP_WR, S_SC_RD, S_SC_WAIT, S_SC_WR
    } state_t;

    state_t      state, state_nx;
    logic [2:0]  op_q;
    logic        hires_q;
    logic [11:0] ptr;
    logic [4:0]  nrows;
    logic [3:0]  xb;
    logic [2:0]  xs;
    logic [5:0]  y0;
    logic [3:0]  n_q;
    logic [5:0]  r_cnt;
    logic [3:0]  b_cnt;
    logic [1:0]  k_cnt;
    logic [7:0]  spr_hi, spr_lo, old_q, carry;

    // Sprite geometry
    logic        wide;
    logic [23:0] pat24;
    logic [7:0]  pat_byte;
    logic [5:0]  sp_row_sum;
    logic [3:0]  sp_col_sum;
    logic [9:0]  sp_addr;
    logic        sp_row_last, sp_last;

    assign wide       = (op_q == OP_SPRITE16);
    assign pat24      = (wide ? {spr_hi, spr_lo, 8'h00} : {spr_hi, 16'h0000}) >> xs;
    assign sp_row_sum = y0 + r_cnt;
    assign sp_col_sum = xb + {2'b00, k_cnt};
    // Lores wraps row at 32 and byte column at 8, so bytes 8..15 are never touched
    assign sp_addr    = hires_q ? {sp_row_sum, sp_col_sum}
                                : {1'b0, sp_row_sum[4:0], 1'b0, sp_col_sum[2:0]};
    assign sp_row_last = (k_cnt == (wide ? 2'd2 : 2'd1));
    assign sp_last     = sp_row_last && (r_cnt[4:0] == nrows - 5'd1);

    always_comb begin
        case (k_cnt)
            2'd0:    pat_byte = pat24[23:16];
            2'd1:    pat_byte = pat24[15:8];
            default: pat_byte = pat24[7:0];
        endcase
    end

    // Scroll geometry
    logic [5:0] h_max;
    logic [3:0] bw_max;
    logic       zero_fill, sc_row_end, sc_last;
    logic [5:0] src_row;
    logic [7:0] sc_data;

    assign h_max      = hires_q ? 6'd63 : 6'd31;
    assign bw_max     = hires_q ? 4'd15 : 4'd7;
    assign zero_fill  = (op_q == OP_SCROLL_DOWN) && (r_cnt < {2'b00, n_q});
    assign src_row    = (op_q == OP_SCROLL_DOWN) ? (r_cnt - {2'b00, n_q}) : r_cnt;
    assign sc_row_end = (op_q == OP_SCROLL_LEFT) ? (b_cnt == 4'd0) : (b_cnt == bw_max);
    assign sc_last    = sc_row_end && ((op_q == OP_SCROLL_DOWN) ? (r_cnt == 6'd0) : (r_cnt == h_max));

    // carry holds the unmodified neighbour already visited on this row
    always_comb begin
        case (op_q)
            OP_SCROLL_DOWN:  sc_data = zero_fill ? 8'h00 : old_q;
            OP_SCROLL_RIGHT: sc_data = {carry[SCROLL_X-1:0], old_q[7:SCROLL_X]};
            OP_SCROLL_LEFT:  sc_data = {old_q[7-SCROLL_X:0], carry[7:8-SCROLL_X]};
            default:         sc_data = old_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge res) begin
        if (res) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (enable) begin
                    case (op)
                        OP_CLEAR:        state_nx = S_CLEAR;
                        OP_SPRITE,
                        OP_SPRITE16:     state_nx = S_FETCH;
                        OP_SCROLL_DOWN:  state_nx = (destY[3:0] != 4'd0) ? S_SC_RD : S_IDLE;
                        OP_SCROLL_RIGHT,
                        OP_SCROLL_LEFT:  state_nx = S_SC_RD;
                        default:         state_nx = S_IDLE;
                    endcase
                end
            end
            S_CLEAR:   if ({r_cnt, b_cnt} == 10'h3FF) state_nx = S_IDLE;
            S_FETCH:   state_nx = wide ? S_FETCH2 : S_CAPTURE;
            S_FETCH2:  state_nx = S_CAPTURE;
            S_CAPTURE: state_nx = S_SP_RD;
            S_SP_RD:   state_nx = S_SP_WAIT;
            S_SP_WAIT: state_nx = S_SP_WR;
            S_SP_WR:   state_nx = sp_last ? S_IDLE : (sp_row_last ? S_FETCH : S_SP_RD);
            S_SC_RD:   state_nx = S_SC_WAIT;
            S_SC_WAIT: state_nx = S_SC_WR;
            S_SC_WR:   state_nx = sc_last ? S_IDLE : S_SC_RD;
            default:   state_nx = S_IDLE;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            op_q <= 3'd0; hires_q <= 1'b0; ptr <= 12'd0; nrows <= 5'd0;
            xb <= 4'd0; xs <= 3'd0; y0 <= 6'd0; n_q <= 4'd0;
            r_cnt <= 6'd0; b_cnt <= 4'd0; k_cnt <= 2'd0;
            spr_hi <= 8'h00; spr_lo <= 8'h00; old_q <= 8'h00; carry <= 8'h00;
            collision <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (enable) begin
                    op_q    <= op;
                    hires_q <= hires;
                    ptr     <= src;
                    nrows   <= (op == OP_SPRITE16) ? 5'd16 : {1'b0, srcHeight};
                    xb      <= destX[6:3];
                    xs      <= destX[2:0];
                    y0      <= hires ? destY : {1'b0, destY[4:0]};
                    n_q     <= destY[3:0];
                    r_cnt   <= (op == OP_SCROLL_DOWN) ? (hires ? 6'd63 : 6'd31) : 6'd0;
                    b_cnt   <= (op == OP_SCROLL_LEFT) ? (hires ? 4'd15 : 4'd7) : 4'd0;
                    k_cnt   <= 2'd0;
                    carry   <= 8'h00;
                    if (op == OP_SPRITE || op == OP_SPRITE16) collision <= 1'b0;
                end
                S_CLEAR:   {r_cnt, b_cnt} <= {r_cnt, b_cnt} + 10'd1;
                S_FETCH:   ptr <= ptr + 12'd1;
                S_FETCH2: begin
                    ptr    <= ptr + 12'd1;
                    spr_hi <= ram_out;
                end
                S_CAPTURE: begin
                    if (wide) spr_lo <= ram_out;
                    else      spr_hi <= ram_out;
                end
                S_SP_WAIT: begin
                    old_q <= fb_out;
                    if ((fb_out & pat_byte) != 8'h00) collision <= 1'b1;
                end
                S_SP_WR: begin
                    if (sp_row_last) begin
                        k_cnt <= 2'd0;
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        k_cnt <= k_cnt + 2'd1;
                    end
                end
                S_SC_WAIT: old_q <= fb_out;
                S_SC_WR: begin
                    carry <= sc_row_end ? 8'h00 : old_q;
                    if (op_q == OP_SCROLL_LEFT) begin
                        if (b_cnt == 4'd0) begin
                            b_cnt <= bw_max;
                            r_cnt <= r_cnt + 6'd1;
                        end else begin
                            b_cnt <= b_cnt - 4'd1;
                        end
                    end else if (b_cnt == bw_max) begin
                        b_cnt <= 4'd0;
                        r_cnt <= (op_q == OP_SCROLL_DOWN) ? (r_cnt - 6'd1) : (r_cnt + 6'd1);
                    end else begin
                        b_cnt <= b_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        done     = (state == S_IDLE) && !enable;
        ram_en   = 1'b0;
        ram_addr = ptr;
        fb_en    = 1'b0;
        fb_wr    = 1'b0;
        fb_addr  = 10'd0;
        fb_in    = 8'h00;
        case (state)
            S_CLEAR: begin
                fb_en = 1'b1; fb_wr = 1'b1; fb_addr = {r_cnt, b_cnt};
            end
            S_FETCH, S_FETCH2: ram_en = 1'b1;
            S_SP_RD: begin
                fb_en = 1'b1; fb_addr = sp_addr;
            end
            S_SP_WAIT: fb_addr = sp_addr;
            S_SP_WR: begin
                fb_en = 1'b1; fb_wr = 1'b1; fb_addr = sp_addr; fb_in = old_q ^ pat_byte;
            end
            S_SC_RD: begin
                fb_en = !zero_fill; fb_addr = {src_row, b_cnt};
            end
            S_SC_WAIT: fb_addr = {r_cnt, b_cnt};
            S_SC_WR: begin
                fb_en = 1'b1; fb_wr = 1'b1; fb_addr = {r_cnt, b_cnt}; fb_in = sc_data;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_chip8_blitter.sv
// tb/tb_chip8_blitter.sv - directed self-checking bench for chip8_blitter
module tb_chip8_blitter;

    logic        clk = 1'b0;
    logic        res;
    logic        hires;
    logic [2:0]  op;
    logic [11:0] src;
    logic [3:0]  src_height;
    logic [6:0]  dest_x;
    logic [5:0]  dest_y;
    logic        enable;
    logic        done;
    logic        collision;
    logic        ram_en;
    logic [11:0] ram_addr;
    logic [7:0]  ram_out;
    logic        fb_en;
    logic        fb_wr;
    logic [9:0]  fb_addr;
    logic [7:0]  fb_in;
    logic [7:0]  fb_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] fb_mem  [0:1023];
    logic [7:0] ram_mem [0:4095];
    int         wr_count = 0;
    logic       fill_en = 1'b0;
    logic [7:0] fill_val = 8'h00;
    logic       poke_en = 1'b0;
    logic [9:0] poke_addr = 10'd0;
    logic [7:0] poke_data = 8'h00;

    chip8_blitter #(.SCROLL_X(4)) dut (
        .clk(clk), .res(res), .hires(hires), .op(op), .src(src),
        .srcHeight(src_height), .destX(dest_x), .destY(dest_y),
        .enable(enable), .done(done), .collision(collision),
        .ram_en(ram_en), .ram_addr(ram_addr), .ram_out(ram_out),
        .fb_en(fb_en), .fb_wr(fb_wr), .fb_addr(fb_addr), .fb_in(fb_in), .fb_out(fb_out)
    );

    always #5 clk = ~clk;

    // Framebuffer and main RAM models, one-cycle read latency
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 1024; i++) fb_mem[i] = fill_val;
        end else if (poke_en) begin
            fb_mem[poke_addr] = poke_data;
        end
        if (fb_en) begin
            if (fb_wr) begin
                fb_mem[fb_addr] = fb_in;
                wr_count = wr_count + 1;
            end else begin
                fb_out <= fb_mem[fb_addr];
            end
        end
        if (ram_en) ram_out <= ram_mem[ram_addr];
    end

    task automatic fill(input logic [7:0] v);
        @(negedge clk);
        fill_val = v;
        fill_en  = 1'b1;
        @(negedge clk);
        fill_en  = 1'b0;
    endtask

    task automatic poke(input logic [9:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_addr = a;
        poke_data = d;
        poke_en   = 1'b1;
        @(negedge clk);
        poke_en   = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] o, input logic h, input logic [11:0] s,
                            input logic [3:0] sh, input logic [6:0] dx, input logic [5:0] dy);
        @(negedge clk);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL start_idle_done: got %b expected 1", done);
        end
        op = o; hires = h; src = s; src_height = sh; dest_x = dx; dest_y = dy;
        enable = 1'b1;
        #1;
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_cycle_done: got %b expected 0", done);
        end
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic wait_done(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_timeout: done got %b expected 1 within %0d cycles", name, done, bound);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic test_reset;
        res = 1'b1; enable = 1'b0; hires = 1'b0; op = 3'd0; src = 12'd0;
        src_height = 4'd0; dest_x = 7'd0; dest_y = 6'd0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({done, collision, ram_en, fb_en, fb_wr} !== 5'b10000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 10000", {done, collision, ram_en, fb_en, fb_wr});
        end
        res = 1'b0;
        fill(8'h00);
    endtask

    task automatic test_sprite_aligned;
        int w0;
        ram_mem[12'h300] = 8'hF0;
        fill(8'h00);
        poke(10'h022, 8'h5A);
        w0 = wr_count;
        start_op(3'd1, 1'b1, 12'h300, 4'd1, 7'd8, 6'd2);
        wait_done(200, "sprite_aligned");
        chk8("aligned_fb21", fb_mem[10'h021], 8'hF0);
        chk8("aligned_fb22", fb_mem[10'h022], 8'h5A);
        chk8("aligned_coll0", {7'd0, collision}, 8'h00);
        chk8("aligned_writes", 8'(wr_count - w0), 8'd2);
        start_op(3'd1, 1'b1, 12'h300, 4'd1, 7'd8, 6'd2);
        wait_done(200, "sprite_redraw");
        chk8("redraw_fb21", fb_mem[10'h021], 8'h00);
        chk8("redraw_fb22", fb_mem[10'h022], 8'h5A);
        chk8("redraw_coll1", {7'd0, collision}, 8'h01);
    endtask

    task automatic test_clear;
        int w0;
        int nz;
        fill(8'hFF);
        w0 = wr_count;
        start_op(3'd0, 1'b0, 12'h000, 4'd0, 7'd0, 6'd0);
        @(negedge clk);
        chk8("clear_busy_done", {7'd0, done}, 8'h00);
        wait_done(1200, "clear");
        nz = 0;
        for (int i = 0; i < 1024; i++) if (fb_mem[i] !== 8'h00) nz++;
        n_tests++;
        if (nz != 0) begin
            n_fail++;
            $display("FAIL clear_all_zero: got %0d nonzero bytes expected 0", nz);
        end
        n_tests++;
        if (wr_count - w0 != 1024) begin
            n_fail++;
            $display("FAIL clear_writes: got %0d expected 1024", wr_count - w0);
        end
        chk8("clear_keeps_coll", {7'd0, collision}, 8'h01);
    endtask

    task automatic test_reset_mid_clear;
        int snap;
        fill(8'hFF);
        start_op(3'd0, 1'b1, 12'h000, 4'd0, 7'd0, 6'd0);
        repeat (100) @(negedge clk);
        res = 1'b1;
        #1;
        snap = wr_count;
        chk8("midreset_done", {7'd0, done}, 8'h01);
        chk8("midreset_fb_en", {7'd0, fb_en}, 8'h00);
        repeat (4) @(negedge clk);
        n_tests++;
        if (wr_count != snap) begin
            n_fail++;
            $display("FAIL midreset_no_writes: got %0d expected %0d", wr_count, snap);
        end
        chk8("midreset_fb0", fb_mem[0], 8'h00);
        chk8("midreset_fb1000", fb_mem[1000], 8'hFF);
        chk8("midreset_coll", {7'd0, collision}, 8'h00);
        res = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_sprite_wrap;
        ram_mem[12'h310] = 8'hFF;
        fill(8'h00);
        poke(10'd504, 8'h33);
        start_op(3'd1, 1'b0, 12'h310, 4'd1, 7'd60, 6'd31);
        wait_done(200, "sprite_wrap");
        chk8("wrap_col7", fb_mem[31*16+7], 8'h0F);
        chk8("wrap_col0", fb_mem[31*16+0], 8'hF0);
        chk8("wrap_col8_untouched", fb_mem[31*16+8], 8'h33);
        // RAM address wraps 0xFFF -> 0x000 between rows
        ram_mem[12'hFFF] = 8'h81;
        ram_mem[12'h000] = 8'h18;
        start_op(3'd1, 1'b1, 12'hFFF, 4'd2, 7'd16, 6'd10);
        wait_done(200, "sprite_ramwrap");
        chk8("ramwrap_row10", fb_mem[10*16+2], 8'h81);
        chk8("ramwrap_row11", fb_mem[11*16+2], 8'h18);
        chk8("ramwrap_coll", {7'd0, collision}, 8'h00);
    endtask

    task automatic test_sprite16;
        int w0;
        int rows [16];
        for (int i = 0; i < 32; i++) ram_mem[12'h400 + i] = 8'hFF;
        fill(8'h00);
        w0 = wr_count;
        start_op(3'd2, 1'b1, 12'h400, 4'd0, 7'd0, 6'd62);
        wait_done(400, "sprite16");
        rows[0] = 62; rows[1] = 63;
        for (int i = 2; i < 16; i++) rows[i] = i - 2;
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if ({fb_mem[rows[i]*16], fb_mem[rows[i]*16+1], fb_mem[rows[i]*16+2]} !== 24'hFFFF00) begin
                n_fail++;
                $display("FAIL sprite16_row%0d: got %h%h%h expected ffff00", rows[i],
                         fb_mem[rows[i]*16], fb_mem[rows[i]*16+1], fb_mem[rows[i]*16+2]);
            end
        end
        chk8("sprite16_row14", fb_mem[14*16], 8'h00);
        chk8("sprite16_row61", fb_mem[61*16], 8'h00);
        chk8("sprite16_writes", 8'(wr_count - w0), 8'd48);
    endtask

    task automatic test_scroll_down;
        int w0;
        fill(8'h00);
        poke(10'd0, 8'hAA);
        poke(10'd15, 8'hAA);
        poke(10*16+3, 8'h5C);
        w0 = wr_count;
        start_op(3'd3, 1'b1, 12'h000, 4'd0, 7'd0, 6'd4);
        wait_done(4000, "scroll_down");
        chk8("sdown_row4_b0", fb_mem[4*16], 8'hAA);
        chk8("sdown_row4_b15", fb_mem[4*16+15], 8'hAA);
        chk8("sdown_row0_b0", fb_mem[0], 8'h00);
        chk8("sdown_row0_b15", fb_mem[15], 8'h00);
        chk8("sdown_row14_b3", fb_mem[14*16+3], 8'h5C);
        chk8("sdown_row10_b3", fb_mem[10*16+3], 8'h00);
        n_tests++;
        if (wr_count - w0 != 1024) begin
            n_fail++;
            $display("FAIL sdown_writes: got %0d expected 1024", wr_count - w0);
        end
        chk8("sdown_coll", {7'd0, collision}, 8'h00);
        // Lores: only the 64x32 area is rewritten
        fill(8'h00);
        poke(10'd640, 8'h77);
        poke(10'd9, 8'h66);
        poke(1*16+2, 8'h3C);
        w0 = wr_count;
        start_op(3'd3, 1'b0, 12'h000, 4'd0, 7'd0, 6'd2);
        wait_done(1200, "scroll_down_lores");
        chk8("sdown_lo_row3", fb_mem[3*16+2], 8'h3C);
        chk8("sdown_lo_row1", fb_mem[1*16+2], 8'h00);
        chk8("sdown_lo_row40", fb_mem[640], 8'h77);
        chk8("sdown_lo_col9", fb_mem[9], 8'h66);
        n_tests++;
        if (wr_count - w0 != 256) begin
            n_fail++;
            $display("FAIL sdown_lo_writes: got %0d expected 256", wr_count - w0);
        end
    endtask

    task automatic test_scroll_right_left;
        fill(8'h00);
        poke(5*16+0, 8'hFF);
        poke(7*16+15, 8'h0F);
        start_op(3'd4, 1'b1, 12'h000, 4'd0, 7'd0, 6'd0);
        wait_done(4000, "scroll_right");
        chk8("sright_b0", fb_mem[5*16+0], 8'h0F);
        chk8("sright_b1", fb_mem[5*16+1], 8'hF0);
        chk8("sright_b2", fb_mem[5*16+2], 8'h00);
        chk8("sright_edge_lost", fb_mem[7*16+15], 8'h00);
        chk8("sright_no_row_carry", fb_mem[8*16+0], 8'h00);
        poke(9*16+0, 8'hF0);
        start_op(3'd5, 1'b1, 12'h000, 4'd0, 7'd0, 6'd0);
        wait_done(4000, "scroll_left");
        chk8("sleft_b0", fb_mem[5*16+0], 8'hFF);
        chk8("sleft_b1", fb_mem[5*16+1], 8'h00);
        chk8("sleft_edge_lost", fb_mem[9*16+0], 8'h00);
        chk8("sleft_coll", {7'd0, collision}, 8'h00);
    endtask

    task automatic test_handshake;
        int w0;
        ram_mem[12'h500] = 8'hC3;
        fill(8'h00);
        w0 = wr_count;
        start_op(3'd1, 1'b1, 12'h500, 4'd1, 7'd32, 6'd20);
        @(negedge clk);
        op = 3'd0;
        enable = 1'b1;
        #1;
        chk8("busy_enable_done", {7'd0, done}, 8'h00);
        @(negedge clk);
        enable = 1'b0;
        wait_done(200, "handshake");
        chk8("handshake_fb", fb_mem[20*16+4], 8'hC3);
        chk8("handshake_fb_next", fb_mem[20*16+5], 8'h00);
        chk8("handshake_writes", 8'(wr_count - w0), 8'd2);
        repeat (3) @(negedge clk);
        chk8("handshake_stays_idle", {7'd0, done}, 8'h01);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram_mem[i] = 8'h00;
        test_reset;
        test_sprite_aligned;
        test_clear;
        test_reset_mid_clear;
        test_sprite_wrap;
        test_sprite16;
        test_scroll_down;
        test_scroll_right_left;
        test_handshake;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/chip8_blitter.md
Name: chip8_blitter

Overview:
- Drawing engine directly downstream of the CPU's blit_* outputs.
- Executes sprite XOR-draw, screen clear and scroll operations on a 128x64 1-bpp framebuffer RAM, reading sprite data from main RAM.
- Returns done and collision to the CPU.
- The video scanout reads the same framebuffer through its own port (not part of this block).

Parameters:
SCROLL_X, 4, horizontal scroll distance in pixels for SCROLL_LEFT/RIGHT (legal 1..7)

Ports:
clk  in  1  system clock
res  in  1  reset, asynchronous, active-high
hires  in  1  1: 128x64 active area; 0: 64x32 active area (top-left of buffer)
op  in  3  operation: 0 CLEAR, 1 SPRITE, 2 SPRITE_16, 3 SCROLL_DOWN, 4 SCROLL_RIGHT, 5 SCROLL_LEFT (blitter.vh)
src  in  12  sprite start address in main RAM
srcHeight  in  4  sprite rows for SPRITE (1..15)
destX  in  7  sprite X; SCROLL ops ignore it
destY  in  6  sprite Y; for SCROLL_DOWN, destY[3:0] = rows to scroll
enable  in  1  start strobe, one cycle, sampled only when idle
done  out  1  combinational: idle AND NOT enable
collision  out  1  registered; 1 if the last sprite cleared any set pixel
ram_en  out  1  main RAM read enable (dedicated read port)
ram_addr  out  12  main RAM address
ram_out  in  8  main RAM data, valid 1 cycle after ram_en
fb_en  out  1  framebuffer enable
fb_wr  out  1  framebuffer write
fb_addr  out  10  byte address = row*16 + byteCol
fb_in  out  8  write data, MSB = leftmost pixel
fb_out  in  8  read data, valid 1 cycle after fb_en with fb_wr=0

Behaviour:
- Reset (async) sets state IDLE, ram_en=0, fb_en=0, fb_wr=0, collision=0 and clears all counters. A reset mid-operation abandons it with no further writes; done is high after reset.
- Width W = hires?128:64, height H = hires?64:32. Byte columns per row BW = W/8.
- IDLE: enable=1 latches op/src/srcHeight/destX/destY/hires and leaves IDLE on the same edge. done drops combinationally in the enable cycle, so the CPU never sees a stale done. enable while busy is ignored.
- CLEAR: writes 0x00 to all 1024 fb bytes, one per cycle, regardless of hires. Returns to IDLE after 1024 write cycles. collision unchanged.
- SPRITE / SPRITE_16:
  - Width w is 8 or 16; rows is srcHeight or 16; bytes/row is 1 or 2, read sequentially from src.
  - collision is cleared at start.
  - Start coordinates: x0 = destX mod W, y0 = destY mod H. Pixels wrap: row (y0+r) mod H, byte column (x0/8 + k) mod BW.
  - Per row: fetch sprite byte(s), then form pattern = spriteBits shifted right by x0[2:0] across 2 (w=8) or 3 (w=16) fb bytes.
  - For each of those bytes: read, wait, write old^pat. Set collision if (old & pat) != 0.
  - All 2/3 bytes are RMW'd even when x0 is aligned.
  - Bound: at most 3 fetch + 9 fb cycles per row.
- SCROLL_DOWN n (n=destY[3:0], 0 means no-op return):
  - Rows are processed from H-1 down to 0, byte by byte.
  - Row y gets row y-n (read, wait, write), or 0x00 when y<n. Only the active H x W area is touched.
- SCROLL_RIGHT: per row, bytes processed left to right with a carry of the previous old byte. new[b] = {oldPrev[SCROLL_X-1:0], old[b][7:SCROLL_X]}; oldPrev = 0 at b=0.
- SCROLL_LEFT: per row, bytes processed right to left. new[b] = {old[b][7-SCROLL_X:0], oldNext[7:8-SCROLL_X]}; oldNext = 0 at b=BW-1.
- Scroll ops leave collision unchanged.
- Address arithmetic:
  - 12-bit RAM address wraps 0xFFF→0x000.
  - FB row index is 6 bits and byte column is 4 bits. In lores, the 3-bit column wrap keeps bytes 8..15 untouched.
- ram_en and fb_en are deasserted in IDLE. fb_wr is high only in write cycles.

Test Plan:
- Reset, then CLEAR: pre-fill fb with 0xFF, enable op=0 → 1024 writes of 0x00, done returns high, collision stays 0; async res pulse mid-clear → writes stop immediately, done=1.
- SPRITE at aligned X: hires=1, RAM[0x300]=0xF0, srcHeight=1, destX=8, destY=2 → fb[0x21]=0xF0, fb[0x22] unchanged, collision=0. Repeat → fb[0x21]=0x00, collision=1.
- SPRITE unaligned with wrap: hires=0, RAM=0xFF, destX=60, destY=31 → fb[31*16+7]=0x0F, fb[31*16+0]=0xF0, byte 8 untouched.
- SPRITE_16: 32 bytes 0xFF at 0x400, destX=0, destY=62, hires=1 → rows 62,63,0..13, bytes 0-1 = 0xFF.
- SCROLL_DOWN 4 in hires: row 0 = 0xAA → row 4 = 0xAA, rows 0-3 = 0x00; SCROLL_RIGHT: row byte0=0xFF, byte1=0x00 → 0x0F,0xF0; SCROLL_LEFT reverses it.
- Handshake: in the cycle enable=1, done=0 combinationally. Second enable while busy is ignored and the first op completes unchanged.
